bcd_stopwatch_ctrl: RTL and testbench
=====================================

BCD_STOPWATCH_CTRL -- requirements
Module: bcd_stopwatch_ctrl

Interface
REQ-001 Parameter NDIGITS, default 4: number of BCD digits of the controlled counter.
REQ-002 Parameter PRESCALE, default 100: clk cycles per count tick, legal range 2 to 2^24.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 start_stop  input  1  single-cycle pulse; toggles run/pause.
REQ-006 clear  input  1  single-cycle pulse; returns the stopwatch to zero.
REQ-007 lap  input  1  single-cycle pulse; freezes or releases the displayed value.
REQ-008 bcd_in  input  4*NDIGITS  live count from the N-digit BCD counter.
REQ-009 eos  input  1  counter end-of-scale flag (all digits 9).
REQ-010 overflow  input  1  counter most-significant carry-out.
REQ-011 cnt_en  output  1  count enable to the counter.
REQ-012 cnt_clr  output  1  synchronous clear pulse to the counter.
REQ-013 display_bcd  output  4*NDIGITS  value to display.
REQ-014 running  output  1  high in RUN.
REQ-015 full  output  1  high in FULL.
REQ-016 lap_hold  output  1  high while display is frozen.
REQ-017 err  output  1  sticky overflow error flag.

Function
REQ-018 FSM states IDLE, RUN, PAUSE, FULL; one state per cycle, registered.
REQ-019 IDLE: start_stop -> RUN; clear -> stays IDLE, cnt_clr pulsed.
REQ-020 RUN: start_stop -> PAUSE; eos high -> FULL; clear ignored; eos takes priority over start_stop.
REQ-021 PAUSE: start_stop -> RUN; clear -> IDLE; clear wins over simultaneous start_stop.
REQ-022 FULL: clear -> IDLE; start_stop ignored.
REQ-023 Prescaler counts 0..PRESCALE-1 only in RUN, wraps to 0; tick is high for one cycle when prescaler equals PRESCALE-1.
REQ-024 Prescaler holds its value in PAUSE and FULL and is zeroed on every entry to IDLE.
REQ-025 cnt_en = tick AND state==RUN AND NOT eos; combinational from registered signals only.
REQ-026 cnt_clr is registered, high exactly one cycle after any accepted clear; never high in the same cycle as cnt_en.
REQ-027 err sets on any cycle with overflow high, stays set until the cycle after an accepted clear.
REQ-028 running and full are decoded directly from the state register.

Reset
REQ-029 On rst low: state IDLE, prescaler 0, cnt_en 0, cnt_clr 0, err 0, lap_hold 0, lap register 0, display_bcd equal to bcd_in.
REQ-030 Reset mid-RUN aborts immediately; after rst release no cnt_en pulse occurs before a start_stop.
REQ-031 Reset does not issue cnt_clr; the counter is reset by the same rst line.

Configuration
REQ-032 Macro BCD_STOPWATCH_LAP_EN compiles in the lap function.
REQ-033 With the macro: lap in RUN or PAUSE with lap_hold low captures bcd_in into the lap register and sets lap_hold; lap with lap_hold high clears lap_hold; entry to IDLE clears lap_hold; display_bcd = lap_hold ? lap register : bcd_in.
REQ-034 Without the macro: lap input ignored, lap_hold tied 0, no lap register, display_bcd = bcd_in.

Verification (NDIGITS=2, PRESCALE=4)
REQ-035 Reset then start_stop -> cnt_en pulses every 4th cycle, first pulse 4 cycles after RUN entry, running=1.
REQ-036 start_stop at prescaler=2, wait 10 cycles, start_stop again -> no cnt_en while paused; next cnt_en exactly 2 cycles after RUN re-entry.
REQ-037 Run with counter reaching 99 -> eos high, cnt_en stays 0, full=1, bcd_in held at 0x99; clear -> IDLE, cnt_clr one cycle.
REQ-038 PAUSE with start_stop and clear in the same cycle -> IDLE, cnt_clr pulse, running=0.
REQ-039 Force overflow=1 for one cycle -> err=1 and remains 1 until the cycle after an accepted clear.
REQ-040 With BCD_STOPWATCH_LAP_EN, lap at bcd_in=0x37 -> display_bcd=0x37 while bcd_in advances; second lap -> display_bcd tracks bcd_in.

Source files
------------

// File: rtl/bcd_stopwatch_ctrl_if.sv
// Stopwatch controller bus: operator pulses, counter status in, counter
// control and display/status out.
//   master: drives start_stop, clear, lap, bcd_in, eos, overflow
//   slave : drives cnt_en, cnt_clr, display_bcd, running, full, lap_hold, err
interface bcd_stopwatch_ctrl_if #(
  parameter int unsigned NDIGITS = 4
);
  localparam int unsigned DW = 4 * NDIGITS;

  logic          start_stop;
  logic          clear;
  logic          lap;
  logic [DW-1:0] bcd_in;
  logic          eos;
  logic          overflow;
  logic          cnt_en;
  logic          cnt_clr;
  logic [DW-1:0] display_bcd;
  logic          running;
  logic          full;
  logic          lap_hold;
  logic          err;

  modport master (
    output start_stop, clear, lap, bcd_in, eos, overflow,
    input  cnt_en, cnt_clr, display_bcd, running, full, lap_hold, err
  );

  modport slave (
    input  start_stop, clear, lap, bcd_in, eos, overflow,
    output cnt_en, cnt_clr, display_bcd, running, full, lap_hold, err
  );
endinterface

// File: rtl/bcd_stopwatch_ctrl.sv
// Run/pause/clear controller for an external N-digit BCD counter.
// A prescaler turns clk into count ticks while running; the FSM stops at
// end-of-scale and waits for clear.
// Optional lap-freeze of the displayed value: define BCD_STOPWATCH_LAP_EN.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous reset, active low
//   bus  - bcd_stopwatch_ctrl_if.slave
//            in : start_stop, clear, lap (pulses), bcd_in, eos, overflow
//            out: cnt_en, cnt_clr, display_bcd, running, full, lap_hold, err
module bcd_stopwatch_ctrl #(
  parameter int unsigned NDIGITS  = 4,
  parameter int unsigned PRESCALE = 100
) (
  input  logic                 clk,
  input  logic                 rst,
  bcd_stopwatch_ctrl_if.slave  bus
);

  localparam int unsigned DW = 4 * NDIGITS;
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_FULL  = 2'd3
  } state_t;

  state_t        state_q;
  state_t        state_nxt;
  logic [PW-1:0] presc_q;
  logic          cnt_clr_q;
  logic          err_q;

  logic          tick_c;
  logic          clear_acc_c;
  logic          running_c;
  logic          full_c;
  logic          presc_adv_c;
  logic [DW-1:0] live_bcd;

  assign live_bcd = bus.bcd_in;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_nxt;
  end

  // Next-state logic; clear takes precedence over start_stop wherever it is accepted
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE:  if (!bus.clear && bus.start_stop) state_nxt = S_RUN;
      S_RUN: begin
        if (bus.eos)             state_nxt = S_FULL;
        else if (bus.start_stop) state_nxt = S_PAUSE;
      end
      S_PAUSE: begin
        if (bus.clear)           state_nxt = S_IDLE;
        else if (bus.start_stop) state_nxt = S_RUN;
      end
      S_FULL:  if (bus.clear) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the state register
  always_comb begin
    clear_acc_c = 1'b0;
    running_c   = 1'b0;
    full_c      = 1'b0;
    tick_c      = 1'b0;
    case (state_q)
      S_IDLE, S_PAUSE, S_FULL: clear_acc_c = bus.clear;
      default:                 clear_acc_c = 1'b0;
    endcase
    running_c = (state_q == S_RUN);
    full_c    = (state_q == S_FULL);
    tick_c    = (state_q == S_RUN) && (presc_q == PRESC_MAX);
  end

  // Leaving RUN freezes the phase, except that a tick just consumed wraps so
  // resuming never produces a second enable for the same period.
  assign presc_adv_c = (state_q == S_RUN) && ((state_nxt == S_RUN) || tick_c);

  // Tick prescaler
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
    end else if (state_nxt == S_IDLE) begin
      presc_q <= '0;
    end else if (presc_adv_c) begin
      presc_q <= tick_c ? '0 : presc_q + PW'(1);
    end
  end

  // Counter clear pulse and sticky overflow error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_clr_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cnt_clr_q <= clear_acc_c;
      if (bus.overflow)     err_q <= 1'b1;
      else if (clear_acc_c) err_q <= 1'b0;
    end
  end

  assign bus.cnt_en  = tick_c & ~bus.eos;
  assign bus.cnt_clr = cnt_clr_q;
  assign bus.err     = err_q;
  assign bus.running = running_c;
  assign bus.full    = full_c;

`ifdef BCD_STOPWATCH_LAP_EN
  logic [DW-1:0] lap_q;
  logic          lap_hold_q;

  // Lap capture/release; returning to IDLE always releases the display
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lap_q      <= '0;
      lap_hold_q <= 1'b0;
    end else if (state_nxt == S_IDLE) begin
      lap_hold_q <= 1'b0;
    end else if (bus.lap) begin
      if (lap_hold_q) begin
        lap_hold_q <= 1'b0;
      end else if ((state_q == S_RUN) || (state_q == S_PAUSE)) begin
        lap_q      <= live_bcd;
        lap_hold_q <= 1'b1;
      end
    end
  end

  assign bus.lap_hold    = lap_hold_q;
  assign bus.display_bcd = lap_hold_q ? lap_q : live_bcd;
`else
  logic unused_lap;
  assign unused_lap      = bus.lap;
  assign bus.lap_hold    = 1'b0;
  assign bus.display_bcd = live_bcd;
`endif

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Bench for bcd_stopwatch_ctrl (NDIGITS=2, PRESCALE=4) with a behavioural
// 2-digit BCD counter. Stimulus queues expected levels and expected
// cnt_en/cnt_clr pulse cycles; a negedge monitor checks them.
module tb_bcd_stopwatch_ctrl;

  localparam int ID_RUN  = 0;
  localparam int ID_FULL = 1;
  localparam int ID_ERR  = 2;
  localparam int ID_HOLD = 3;
  localparam int ID_DISP = 4;
  localparam int ID_CLR  = 5;

  typedef struct {
    int          cyc;
    int          id;
    logic [31:0] val;
  } chk_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   t;

  chk_t chk_q[$];
  int   en_q[$];
  int   clr_q[$];

  logic [7:0] cnt;
  logic       load_en;
  logic [7:0] load_val;
  logic       eos_frc;
  logic       ovf_frc;

  bcd_stopwatch_ctrl_if #(.NDIGITS(2)) bus ();

  bcd_stopwatch_ctrl #(.NDIGITS(2), .PRESCALE(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] lo;
    logic [3:0] hi;
    lo = v[3:0];
    hi = v[7:4];
    if (lo == 4'd9) begin
      lo = 4'd0;
      hi = (hi == 4'd9) ? 4'd0 : hi + 4'd1;
    end else begin
      lo = lo + 4'd1;
    end
    return {hi, lo};
  endfunction

  // External counter model
  always @(posedge clk or negedge rst) begin
    if (!rst)             cnt <= 8'h00;
    else if (load_en)     cnt <= load_val;
    else if (bus.cnt_clr) cnt <= 8'h00;
    else if (bus.cnt_en)  cnt <= bcd_inc(cnt);
  end

  assign bus.bcd_in   = cnt;
  assign bus.eos      = (cnt == 8'h99) | eos_frc;
  assign bus.overflow = ovf_frc;

  function automatic string sig_name(input int id);
    case (id)
      ID_RUN:  return "running";
      ID_FULL: return "full";
      ID_ERR:  return "err";
      ID_HOLD: return "lap_hold";
      ID_DISP: return "display_bcd";
      default: return "cnt_clr";
    endcase
  endfunction

  function automatic logic [31:0] actual(input int id);
    case (id)
      ID_RUN:  return 32'(bus.running);
      ID_FULL: return 32'(bus.full);
      ID_ERR:  return 32'(bus.err);
      ID_HOLD: return 32'(bus.lap_hold);
      ID_DISP: return 32'(bus.display_bcd);
      default: return 32'(bus.cnt_clr);
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_lvl(input int c, input int id, input logic [31:0] v);
    chk_t e;
    e.cyc = c;
    e.id  = id;
    e.val = v;
    chk_q.push_back(e);
  endtask

  // Monitor
  always @(negedge clk) begin
    logic [31:0] a;
    for (int i = int'(chk_q.size()) - 1; i >= 0; i--) begin
      if (chk_q[i].cyc == cyc) begin
        n_checks++;
        a = actual(chk_q[i].id);
        if (a !== chk_q[i].val) begin
          n_fail++;
          $display("FAIL %s cycle %0d: actual=0x%0h expected=0x%0h",
                   sig_name(chk_q[i].id), cyc, a, chk_q[i].val);
        end
        chk_q.delete(i);
      end
    end
    while (en_q.size() > 0 && en_q[0] < cyc) begin
      n_checks++;
      n_fail++;
      $display("FAIL cnt_en pulse: actual=none expected=cycle %0d", en_q[0]);
      en_q.delete(0);
    end
    if (bus.cnt_en !== 1'b0) begin
      n_checks++;
      if (en_q.size() > 0 && en_q[0] == cyc) begin
        en_q.delete(0);
      end else begin
        n_fail++;
        $display("FAIL cnt_en pulse: actual=cycle %0d expected=none", cyc);
      end
    end
    while (clr_q.size() > 0 && clr_q[0] < cyc) begin
      n_checks++;
      n_fail++;
      $display("FAIL cnt_clr pulse: actual=none expected=cycle %0d", clr_q[0]);
      clr_q.delete(0);
    end
    if (bus.cnt_clr !== 1'b0) begin
      n_checks++;
      if (clr_q.size() > 0 && clr_q[0] == cyc) begin
        clr_q.delete(0);
      end else begin
        n_fail++;
        $display("FAIL cnt_clr pulse: actual=cycle %0d expected=none", cyc);
      end
    end
  end

  initial begin
    rst = 1'b0;
    bus.start_stop = 1'b0;
    bus.clear = 1'b0;
    bus.lap = 1'b0;
    load_en = 1'b0;
    load_val = 8'h00;
    eos_frc = 1'b0;
    ovf_frc = 1'b0;

    // Reset values
    step(2);
    t = cyc;
    exp_lvl(t, ID_RUN, 0);
    exp_lvl(t, ID_FULL, 0);
    exp_lvl(t, ID_ERR, 0);
    exp_lvl(t, ID_HOLD, 0);
    exp_lvl(t, ID_CLR, 0);
    exp_lvl(t, ID_DISP, 0);
    step(1);
    rst = 1'b1;
    step(2);

    // Start: ticks 4 cycles after RUN entry, then every 4th cycle
    t = cyc;
    bus.start_stop = 1'b1;
    exp_lvl(t + 1, ID_RUN, 1);
    en_q.push_back(t + 4);
    en_q.push_back(t + 8);
    step(1);
    bus.start_stop = 1'b0;
    step(10);

    // Pause at prescaler=2, hold 10 cycles, resume: tick 2 cycles in
    t = cyc;
    bus.start_stop = 1'b1;
    exp_lvl(t + 1, ID_RUN, 0);
    exp_lvl(t + 1, ID_DISP, 32'h02);
    step(1);
    bus.start_stop = 1'b0;
    step(10);
    t = cyc;
    bus.start_stop = 1'b1;
    exp_lvl(t + 1, ID_RUN, 1);
    exp_lvl(t + 1, ID_DISP, 32'h02);
    en_q.push_back(t + 2);
    exp_lvl(t + 3, ID_DISP, 32'h03);
    step(1);
    bus.start_stop = 1'b0;
    step(2);
    t = cyc;
    bus.start_stop = 1'b1;
    exp_lvl(t + 1, ID_RUN, 0);
    step(1);
    bus.start_stop = 1'b0;

    // Lap at 0x37 while counting
    load_val = 8'h37;
    load_en = 1'b1;
    step(1);
    load_en = 1'b0;
    t = cyc;
    bus.start_stop = 1'b1;
    exp_lvl(t + 1, ID_RUN, 1);
    en_q.push_back(t + 4);
    en_q.push_back(t + 8);
    step(1);
    bus.start_stop = 1'b0;
    step(1);
    bus.lap = 1'b1;
`ifdef BCD_STOPWATCH_LAP_EN
    exp_lvl(t + 3, ID_HOLD, 1);
    exp_lvl(t + 3, ID_DISP, 32'h37);
    exp_lvl(t + 6, ID_DISP, 32'h37);
`else
    exp_lvl(t + 3, ID_HOLD, 0);
    exp_lvl(t + 3, ID_DISP, 32'h37);
    exp_lvl(t + 6, ID_DISP, 32'h38);
`endif
    step(1);
    bus.lap = 1'b0;
    step(3);
    bus.lap = 1'b1;
    exp_lvl(t + 7, ID_HOLD, 0);
    exp_lvl(t + 7, ID_DISP, 32'h38);
    exp_lvl(t + 9, ID_DISP, 32'h39);
    step(1);
    bus.lap = 1'b0;
    step(3);
    bus.start_stop = 1'b1;
    exp_lvl(t + 11, ID_RUN, 0);
    step(1);
    bus.start_stop = 1'b0;

    // Run into end-of-scale, start_stop ignored in FULL, clear back to IDLE
    load_val = 8'h98;
    load_en = 1'b1;
    step(1);
    load_en = 1'b0;
    t = cyc;
    bus.start_stop = 1'b1;
    en_q.push_back(t + 3);
    exp_lvl(t + 4, ID_DISP, 32'h99);
    exp_lvl(t + 5, ID_FULL, 1);
    exp_lvl(t + 5, ID_RUN, 0);
    step(1);
    bus.start_stop = 1'b0;
    step(4);
    bus.start_stop = 1'b1;
    exp_lvl(t + 6, ID_FULL, 1);
    step(1);
    bus.start_stop = 1'b0;
    bus.clear = 1'b1;
    clr_q.push_back(t + 7);
    exp_lvl(t + 7, ID_FULL, 0);
    exp_lvl(t + 7, ID_RUN, 0);
    exp_lvl(t + 8, ID_DISP, 32'h00);
    step(1);
    bus.clear = 1'b0;
    step(1);

    // Sticky overflow error; clear ignored in RUN; start+clear in PAUSE
    t = cyc;
    ovf_frc = 1'b1;
    exp_lvl(t + 1, ID_ERR, 1);
    step(1);
    ovf_frc = 1'b0;
    step(3);
    bus.start_stop = 1'b1;
    exp_lvl(t + 4, ID_ERR, 1);
    step(1);
    bus.start_stop = 1'b0;
    step(1);
    bus.clear = 1'b1;
    exp_lvl(t + 7, ID_RUN, 1);
    exp_lvl(t + 8, ID_ERR, 1);
    step(1);
    bus.clear = 1'b0;
    bus.start_stop = 1'b1;
    exp_lvl(t + 8, ID_RUN, 0);
    step(1);
    bus.clear = 1'b1;
    clr_q.push_back(t + 9);
    exp_lvl(t + 9, ID_RUN, 0);
    exp_lvl(t + 9, ID_ERR, 0);
    step(1);
    bus.start_stop = 1'b0;
    bus.clear = 1'b0;
    step(1);

    // Prescaler restarts from zero after IDLE; eos at a tick blocks cnt_en
    t = cyc;
    bus.start_stop = 1'b1;
    exp_lvl(t + 1, ID_RUN, 1);
    en_q.push_back(t + 4);
    exp_lvl(t + 9, ID_FULL, 1);
    step(1);
    bus.start_stop = 1'b0;
    step(7);
    eos_frc = 1'b1;
    step(1);
    eos_frc = 1'b0;
    bus.clear = 1'b1;
    clr_q.push_back(t + 10);
    exp_lvl(t + 10, ID_FULL, 0);
    step(1);
    bus.clear = 1'b0;
    step(1);

    // Clear in IDLE, then reset mid-RUN: no enables before a new start
    t = cyc;
    bus.clear = 1'b1;
    clr_q.push_back(t + 1);
    exp_lvl(t + 1, ID_RUN, 0);
    step(1);
    bus.clear = 1'b0;
    bus.start_stop = 1'b1;
    exp_lvl(t + 2, ID_RUN, 1);
    step(1);
    bus.start_stop = 1'b0;
    step(2);
    rst = 1'b0;
    exp_lvl(t + 4, ID_RUN, 0);
    exp_lvl(t + 4, ID_CLR, 0);
    step(2);
    rst = 1'b1;
    exp_lvl(t + 15, ID_RUN, 0);
    exp_lvl(t + 15, ID_DISP, 32'h00);
    step(12);

    // Nothing expected may be left outstanding
    n_checks++;
    if (chk_q.size() != 0 || en_q.size() != 0 || clr_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover expectations: actual=%0d/%0d/%0d expected=0/0/0",
               chk_q.size(), en_q.size(), clr_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
